// File: rtl/led_pattern_sequencer.sv
// Pattern sequencer for the four board LEDs: OFF/SOLID/BREATHE/BLINK/CHASE
// with a controlled fade-out between patterns. It owns its own slow update tick.
module led_pattern_sequencer #(
    parameter int TICK_DIV    = 800_000,
    parameter int BLINK_TICKS = 64,
    parameter int FADE_STEP   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_mode,
    input  logic [7:0]  cmd_level,
    output logic [31:0] duty,
    output logic        busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_TICKS - 1);
    localparam logic [7:0] STEP = 8'(FADE_STEP);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_SOLID,
        ST_BREATHE,
        ST_BLINK,
        ST_CHASE,
        ST_FADE
    } state_t;

    typedef logic [3:0][7:0] duty_t;

    state_t          state_q, state_d;
    duty_t           duty_q, duty_d;
    logic [7:0]      level_q, level_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            dir_up_q, dir_up_d;
    logic            blink_on_q, blink_on_d;
    logic [1:0]      chase_idx_q, chase_idx_d;
    state_t          pend_mode_q, pend_mode_d;
    logic [7:0]      pend_level_q, pend_level_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;

    logic            tick;
    logic            accept;
    state_t          cmd_state;
    logic            enter;
    state_t          enter_mode;
    logic [7:0]      enter_level;
    logic [7:0]      breathe_val;
    duty_t           faded;

    // Mode codes 5-7 are not defined patterns and behave as OFF.
    function automatic state_t decode_mode(input logic [2:0] m);
        state_t s;
        case (m)
            3'd1:    s = ST_SOLID;
            3'd2:    s = ST_BREATHE;
            3'd3:    s = ST_BLINK;
            3'd4:    s = ST_CHASE;
            default: s = ST_OFF;
        endcase
        return s;
    endfunction

    function automatic duty_t entry_duty(input state_t m, input logic [7:0] lvl);
        duty_t d;
        d = '0;
        case (m)
            ST_SOLID, ST_BLINK: d = {4{lvl}};
            ST_CHASE:           d[0] = lvl;
            default:            d = '0;
        endcase
        return d;
    endfunction

    assign tick      = (tick_cnt_q == TICK_LAST);
    assign cmd_ready = (state_q != ST_FADE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_state = decode_mode(cmd_mode);
    assign busy      = (state_q == ST_FADE);
    assign duty      = duty_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            faded[i] = (duty_q[i] > STEP) ? (duty_q[i] - STEP) : 8'h00;
        end
    end

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        level_d      = level_q;
        phase_d      = phase_q;
        dir_up_d     = dir_up_q;
        blink_on_d   = blink_on_q;
        chase_idx_d  = chase_idx_q;
        pend_mode_d  = pend_mode_q;
        pend_level_d = pend_level_q;
        enter        = 1'b0;
        enter_mode   = ST_OFF;
        enter_level  = 8'h00;
        breathe_val  = duty_q[0];

        tick_cnt_d = tick ? '0 : (tick_cnt_q + TW'(1));

        // An accepted command takes priority; a coincident tick is dropped.
        if (accept) begin
            if (duty_q == '0) begin
                enter       = 1'b1;
                enter_mode  = cmd_state;
                enter_level = cmd_level;
            end else begin
                state_d      = ST_FADE;
                pend_mode_d  = cmd_state;
                pend_level_d = cmd_level;
            end
        end else if (tick) begin
            case (state_q)
                ST_BREATHE: begin
                    if (level_q == 8'h00) begin
                        breathe_val = 8'h00;
                    end else if (dir_up_q) begin
                        if (duty_q[0] >= level_q) begin
                            dir_up_d    = 1'b0;
                            breathe_val = level_q - 8'd1;
                        end else begin
                            breathe_val = duty_q[0] + 8'd1;
                        end
                    end else begin
                        if (duty_q[0] == 8'h00) begin
                            dir_up_d    = 1'b1;
                            breathe_val = 8'd1;
                        end else begin
                            breathe_val = duty_q[0] - 8'd1;
                        end
                    end
                    duty_d = {4{breathe_val}};
                end
                ST_BLINK: begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d    = '0;
                        blink_on_d = !blink_on_q;
                        duty_d     = blink_on_q ? '0 : {4{level_q}};
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                ST_CHASE: begin
                    if (phase_q == PHASE_LAST) begin
                        phase_d     = '0;
                        chase_idx_d = chase_idx_q + 2'd1;
                        for (int i = 0; i < 4; i++) begin
                            duty_d[i] = (chase_idx_d == 2'(i)) ? level_q : 8'h00;
                        end
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
                ST_FADE: begin
                    if (faded == '0) begin
                        enter       = 1'b1;
                        enter_mode  = pend_mode_q;
                        enter_level = pend_level_q;
                    end else begin
                        duty_d = faded;
                    end
                end
                default: ;
            endcase
        end

        // Mode entry is shared by direct accepts and the end of a fade.
        if (enter) begin
            state_d     = enter_mode;
            level_d     = enter_level;
            duty_d      = entry_duty(enter_mode, enter_level);
            phase_d     = '0;
            dir_up_d    = 1'b1;
            blink_on_d  = 1'b1;
            chase_idx_d = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            duty_q       <= '0;
            level_q      <= 8'h00;
            phase_q      <= '0;
            dir_up_q     <= 1'b1;
            blink_on_q   <= 1'b1;
            chase_idx_q  <= 2'd0;
            pend_mode_q  <= ST_OFF;
            pend_level_q <= 8'h00;
            tick_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            level_q      <= level_d;
            phase_q      <= phase_d;
            dir_up_q     <= dir_up_d;
            blink_on_q   <= blink_on_d;
            chase_idx_q  <= chase_idx_d;
            pend_mode_q  <= pend_mode_d;
            pend_level_q <= pend_level_d;
            tick_cnt_q   <= tick_cnt_d;
        end
    end

endmodule
